// File: rtl/cog_lane_dispatcher.sv
// Dispatches CoG receiver figure segments onto NUM_LANES accumulator lanes.
// Round-robin allocation, per-figure tagging, drop counting and frame drain.
module cog_lane_dispatcher #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_aresetn,
    input  logic [DATA_WIDTH-1:0] i_data_image,
    input  logic                  i_data_valid,
    input  logic [10:0]           i_start_point,
    input  logic                  i_start_of_fig,
    input  logic                  i_end_of_fig,
    input  logic                  i_end_of_line,
    input  logic                  i_end_of_frame,
    input  logic                  i_new_frame,
    input  logic [NUM_LANES-1:0]  i_lane_done,
    output logic [NUM_LANES-1:0]  o_lane_start,
    output logic [NUM_LANES-1:0]  o_lane_valid,
    output logic [NUM_LANES-1:0]  o_lane_end,
    output logic [DATA_WIDTH-1:0] o_lane_data,
    output logic [10:0]           o_lane_start_point,
    output logic [10:0]           o_lane_line,
    output logic [NUM_LANES-1:0]  o_busy_mask,
    output logic [CNT_WIDTH-1:0]  o_drop_count,
    output logic                  o_frame_done,
    output logic                  o_err_protocol
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_FIG, S_STREAM, S_DROP, S_FLUSH} state_t;

    state_t               state, state_nxt;
    logic [LW-1:0]        ptr;
    logic [10:0]          line_cnt;
    logic [NUM_LANES-1:0] cur_oh;

    logic [LW-1:0]        scan_idx [NUM_LANES];
    logic [LW-1:0]        grant_idx;
    logic                 grant_found;
    logic [NUM_LANES-1:0] grant_oh;

    logic [NUM_LANES-1:0] start_nxt, valid_nxt, end_nxt;
    logic                 load_data, grant_en, drop_inc, drop_clr, fdone_nxt, err_set;

    // Candidate order for the round-robin scan, starting at the pointer.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_scan
        assign scan_idx[k] = LW'((int'(ptr) + k) % NUM_LANES);
    end

    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!grant_found && !o_busy_mask[scan_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[k];
            end
        end
    end

    assign grant_oh = NUM_LANES'(1) << grant_idx;

    always_comb begin
        state_nxt = state;
        start_nxt = '0;
        valid_nxt = '0;
        end_nxt   = '0;
        load_data = 1'b0;
        grant_en  = 1'b0;
        drop_inc  = 1'b0;
        drop_clr  = 1'b0;
        fdone_nxt = 1'b0;
        err_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_new_frame) begin
                    state_nxt = S_WAIT_FIG;
                    drop_clr  = 1'b1;
                end
            end
            S_WAIT_FIG: begin
                if (i_new_frame) drop_clr = 1'b1;
                if (i_start_of_fig) begin
                    if (grant_found) begin
                        grant_en  = 1'b1;
                        start_nxt = grant_oh;
                        valid_nxt = grant_oh;
                        load_data = 1'b1;
                        if (i_end_of_fig) end_nxt = grant_oh;
                        else state_nxt = S_STREAM;
                    end else begin
                        drop_inc = 1'b1;
                        if (!i_end_of_fig) state_nxt = S_DROP;
                    end
                end else if (i_data_valid) begin
                    err_set = 1'b1;
                end
                // A figure still open at end of frame keeps streaming first.
                if (i_end_of_frame && (!i_start_of_fig || i_end_of_fig)) state_nxt = S_FLUSH;
            end
            S_STREAM: begin
                if (i_new_frame) begin
                    err_set   = 1'b1;
                    drop_clr  = 1'b1;
                    state_nxt = S_WAIT_FIG;
                end else begin
                    if (i_start_of_fig) err_set = 1'b1;
                    if (i_data_valid) begin
                        valid_nxt = cur_oh;
                        load_data = 1'b1;
                    end
                    if (i_end_of_fig) begin
                        end_nxt   = cur_oh;
                        state_nxt = i_end_of_frame ? S_FLUSH : S_WAIT_FIG;
                    end
                end
            end
            S_DROP: begin
                if (i_new_frame) begin
                    err_set   = 1'b1;
                    drop_clr  = 1'b1;
                    state_nxt = S_WAIT_FIG;
                end else begin
                    if (i_start_of_fig) err_set = 1'b1;
                    if (i_end_of_fig) state_nxt = i_end_of_frame ? S_FLUSH : S_WAIT_FIG;
                end
            end
            S_FLUSH: begin
                if (i_data_valid) err_set = 1'b1;
                if (i_new_frame) begin
                    if (o_busy_mask == '0) fdone_nxt = 1'b1;
                    else err_set = 1'b1;
                    drop_clr  = 1'b1;
                    state_nxt = S_WAIT_FIG;
                end else if (o_busy_mask == '0) begin
                    fdone_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state              <= S_IDLE;
            ptr                <= '0;
            line_cnt           <= '0;
            cur_oh             <= '0;
            o_lane_start       <= '0;
            o_lane_valid       <= '0;
            o_lane_end         <= '0;
            o_lane_data        <= '0;
            o_lane_start_point <= '0;
            o_lane_line        <= '0;
            o_busy_mask        <= '0;
            o_drop_count       <= '0;
            o_frame_done       <= 1'b0;
            o_err_protocol     <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_lane_start <= start_nxt;
            o_lane_valid <= valid_nxt;
            o_lane_end   <= end_nxt;
            o_frame_done <= fdone_nxt;
            if (err_set) o_err_protocol <= 1'b1;
            if (load_data) o_lane_data <= i_data_image;

            // Line tag uses the pre-increment count, so a coincident EOL belongs to the next figure.
            if (i_new_frame) line_cnt <= '0;
            else if (i_end_of_line && state != S_IDLE && line_cnt != 11'd2047) line_cnt <= line_cnt + 11'd1;

            o_busy_mask <= (o_busy_mask & ~i_lane_done) | (grant_en ? grant_oh : '0);
            if (grant_en) begin
                cur_oh             <= grant_oh;
                ptr                <= (grant_idx == LW'(NUM_LANES - 1)) ? '0 : grant_idx + LW'(1);
                o_lane_start_point <= i_start_point;
                o_lane_line        <= line_cnt;
            end

            if (drop_clr) o_drop_count <= '0;
            else if (drop_inc && o_drop_count != {CNT_WIDTH{1'b1}}) o_drop_count <= o_drop_count + CNT_WIDTH'(1);
        end
    end

endmodule
